// File: rtl/cp0_core_pkg.sv
// cp0_defs: shared constants for the CP0 register file and exception sequencer.
// Holds register numbers, Status/Cause bit positions, ExcCode values, MTC0
// write masks, exception vectors and the Cause read-back packing helper.
package cp0_defs;

    localparam logic [4:0] CP0_INDEX    = 5'd0;
    localparam logic [4:0] CP0_ENTRYLO0 = 5'd2;
    localparam logic [4:0] CP0_ENTRYLO1 = 5'd3;
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_ENTRYHI  = 5'd10;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam int ST_IE     = 0;
    localparam int ST_EXL    = 1;
    localparam int ST_IM_LSB = 8;
    localparam int ST_BEV    = 22;
    localparam int CA_BD     = 31;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;

    localparam logic [31:0] STATUS_MASK  = 32'h0040_FF03;
    localparam logic [31:0] ENTRYHI_MASK = 32'hFFFF_E0FF;
    localparam logic [31:0] ENTRYLO_MASK = 32'h3FFF_FFFF;
    localparam logic [31:0] INDEX_MASK   = 32'h0000_000F;
    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

    localparam logic [31:0] RESET_VECTOR_EXC  = 32'hBFC0_0380;
    localparam logic [31:0] NORMAL_VECTOR_EXC = 32'h8000_0180;

    // What the sequencer does with the ID instruction this cycle.
    typedef enum logic [1:0] {
        ACT_NONE,
        ACT_EXC,
        ACT_ERET
    } cp0_act_e;

    // Cause read-back: the software IP bits live at [1:0] (the only MTC0
    // writable field), hardware IP[7:2] at [15:10], ExcCode at [6:2], BD at 31.
    function automatic logic [31:0] cause_pack(input logic       bd,
                                               input logic [7:0] ip,
                                               input logic [4:0] code);
        return {bd, 15'b0, ip[7:2], 2'b00, 1'b0, code, ip[1:0]};
    endfunction

endpackage

// File: rtl/cp0_core_timer.sv
// cp0_timer: Count/Compare timer.
// Ports: clk, rst_n; count_wen/compare_wen with wdata load Count/Compare;
// hw_int5 is ORed into ip7; count/compare expose the registers; ip7 is
// Cause.IP[7].
module cp0_timer
    import cp0_defs::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        count_wen,
    input  logic        compare_wen,
    input  logic [31:0] wdata,
    input  logic        hw_int5,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ip7
);

    logic tick_q;
    logic armed_q;
    logic ip7_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q  <= 1'b0;
            count   <= '0;
            compare <= '0;
            armed_q <= 1'b0;
            ip7_q   <= 1'b0;
        end else begin
            tick_q <= ~tick_q;
            if (count_wen)
                count <= wdata;
            else if (tick_q)
                count <= count + 32'd1;
            // A Compare write wins over a match in the same cycle.
            if (compare_wen) begin
                compare <= wdata;
                ip7_q   <= 1'b0;
                armed_q <= 1'b1;
            end else if (armed_q && (count == compare)) begin
                ip7_q   <= 1'b1;
                armed_q <= 1'b0;
            end
        end
    end

    assign ip7 = ip7_q | hw_int5;

endmodule

// File: rtl/cp0_core.sv
// cp0_core: CP0 register file and exception sequencer.
// Ports: MTC0 write (cp0_wen_i/cp0_addr_i/cp0_data_i), MFC0 read (cp0_data_o),
// ERET/SYSCALL with the ID pc/delay-slot flag, hw_int_i interrupt lines, TLB
// write strobes; outputs intr_o, exc_flush_o/exc_target_o PC redirect and
// the current Status/EPC/EntryHi/EntryLo0/EntryLo1 values.
module cp0_core
    import cp0_defs::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cp0_wen_i,
    input  logic [4:0]  cp0_addr_i,
    input  logic [31:0] cp0_data_i,
    output logic [31:0] cp0_data_o,
    input  logic        instr_ERET_i,
    input  logic        instr_SYSCALL_i,
    input  logic [31:0] exc_pc_i,
    input  logic        exc_bd_i,
    input  logic [5:0]  hw_int_i,
    input  logic        cp0_entryhi_wen_i,
    input  logic        cp0_entrylo0_wen_i,
    input  logic        cp0_entrylo1_wen_i,
    output logic        intr_o,
    output logic        exc_flush_o,
    output logic [31:0] exc_target_o,
    output logic [31:0] status_o,
    output logic [31:0] epc_o,
    output logic [31:0] entryhi_o,
    output logic [31:0] entrylo0_o,
    output logic [31:0] entrylo1_o
);

    logic [31:0] index_q, entrylo0_q, entrylo1_q, entryhi_q, status_q, epc_q;
    logic        cause_bd_q;
    logic [4:0]  cause_code_q;
    logic [1:0]  cause_sw_q;
    logic [31:0] count, compare;
    logic        ip7;
    logic [7:0]  ip;
    logic        intr_raw;
    cp0_act_e    act;
    logic        wr_ok;
    logic [31:0] rdata;

    assign ip       = {ip7, hw_int_i[4:0], cause_sw_q};
    assign intr_raw = (|(ip & status_q[ST_IM_LSB +: 8])) & status_q[ST_IE] & ~status_q[ST_EXL];
    assign intr_o   = intr_raw;

    // Redirects are suppressed while rst_n is low so SYSCALL/ERET seen during
    // reset cannot flush the pipeline.
    always_comb begin
        act = ACT_NONE;
        if (rst_n) begin
            if (intr_raw || (instr_SYSCALL_i && !status_q[ST_EXL]))
                act = ACT_EXC;
            else if (instr_ERET_i)
                act = ACT_ERET;
        end
    end

    assign wr_ok = (act == ACT_NONE);

    always_comb begin
        exc_flush_o  = 1'b0;
        exc_target_o = '0;
        case (act)
            ACT_EXC: begin
                exc_flush_o  = 1'b1;
                exc_target_o = status_q[ST_BEV] ? RESET_VECTOR_EXC : NORMAL_VECTOR_EXC;
            end
            ACT_ERET: begin
                exc_flush_o  = 1'b1;
                exc_target_o = epc_q;
            end
            default: ;
        endcase
    end

    cp0_timer u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .count_wen   (cp0_wen_i && wr_ok && (cp0_addr_i == CP0_COUNT)),
        .compare_wen (cp0_wen_i && wr_ok && (cp0_addr_i == CP0_COMPARE)),
        .wdata       (cp0_data_i),
        .hw_int5     (hw_int_i[5]),
        .count       (count),
        .compare     (compare),
        .ip7         (ip7)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_q      <= '0;
            entrylo0_q   <= '0;
            entrylo1_q   <= '0;
            entryhi_q    <= '0;
            status_q     <= STATUS_RESET;
            epc_q        <= '0;
            cause_bd_q   <= 1'b0;
            cause_code_q <= '0;
            cause_sw_q   <= '0;
        end else if (act == ACT_EXC) begin
            epc_q            <= exc_bd_i ? (exc_pc_i - 32'd4) : exc_pc_i;
            cause_bd_q       <= exc_bd_i;
            cause_code_q     <= intr_raw ? EXC_INT : EXC_SYS;
            status_q[ST_EXL] <= 1'b1;
        end else if (act == ACT_ERET) begin
            status_q[ST_EXL] <= 1'b0;
        end else begin
            if (cp0_wen_i) begin
                case (cp0_addr_i)
                    CP0_INDEX:    index_q    <= cp0_data_i & INDEX_MASK;
                    CP0_ENTRYLO0: entrylo0_q <= cp0_data_i & ENTRYLO_MASK;
                    CP0_ENTRYLO1: entrylo1_q <= cp0_data_i & ENTRYLO_MASK;
                    CP0_STATUS:   status_q   <= cp0_data_i & STATUS_MASK;
                    CP0_CAUSE:    cause_sw_q <= cp0_data_i[1:0];
                    CP0_EPC:      epc_q      <= cp0_data_i;
                    default: ;
                endcase
            end
            if (cp0_entryhi_wen_i || (cp0_wen_i && cp0_addr_i == CP0_ENTRYHI))
                entryhi_q <= cp0_data_i & ENTRYHI_MASK;
            if (cp0_entrylo0_wen_i)
                entrylo0_q <= cp0_data_i & ENTRYLO_MASK;
            if (cp0_entrylo1_wen_i)
                entrylo1_q <= cp0_data_i & ENTRYLO_MASK;
        end
    end

    always_comb begin
        rdata = '0;
        case (cp0_addr_i)
            CP0_INDEX:    rdata = index_q;
            CP0_ENTRYLO0: rdata = entrylo0_q;
            CP0_ENTRYLO1: rdata = entrylo1_q;
            CP0_BADVADDR: rdata = '0;
            CP0_COUNT:    rdata = count;
            CP0_ENTRYHI:  rdata = entryhi_q;
            CP0_COMPARE:  rdata = compare;
            CP0_STATUS:   rdata = status_q;
            CP0_CAUSE:    rdata = cause_pack(cause_bd_q, ip, cause_code_q);
            CP0_EPC:      rdata = epc_q;
            default:      rdata = '0;
        endcase
    end

    // Read port is held at 0 while in reset so only status_o is non-zero.
    assign cp0_data_o = rst_n ? rdata : 32'h0;
    assign status_o   = status_q;
    assign epc_o      = epc_q;
    assign entryhi_o  = entryhi_q;
    assign entrylo0_o = entrylo0_q;
    assign entrylo1_o = entrylo1_q;

endmodule

// File: tb/tb_cp0_core.sv
module tb_cp0_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cp0_wen_i = 1'b0;
    logic [4:0]  cp0_addr_i = '0;
    logic [31:0] cp0_data_i = '0;
    logic [31:0] cp0_data_o;
    logic        instr_ERET_i = 1'b0;
    logic        instr_SYSCALL_i = 1'b0;
    logic [31:0] exc_pc_i = '0;
    logic        exc_bd_i = 1'b0;
    logic [5:0]  hw_int_i = '0;
    logic        cp0_entryhi_wen_i = 1'b0;
    logic        cp0_entrylo0_wen_i = 1'b0;
    logic        cp0_entrylo1_wen_i = 1'b0;
    logic        intr_o, exc_flush_o;
    logic [31:0] exc_target_o, status_o, epc_o, entryhi_o, entrylo0_o, entrylo1_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    cp0_core dut (
        .clk(clk), .rst_n(rst_n),
        .cp0_wen_i(cp0_wen_i), .cp0_addr_i(cp0_addr_i), .cp0_data_i(cp0_data_i),
        .cp0_data_o(cp0_data_o),
        .instr_ERET_i(instr_ERET_i), .instr_SYSCALL_i(instr_SYSCALL_i),
        .exc_pc_i(exc_pc_i), .exc_bd_i(exc_bd_i), .hw_int_i(hw_int_i),
        .cp0_entryhi_wen_i(cp0_entryhi_wen_i), .cp0_entrylo0_wen_i(cp0_entrylo0_wen_i),
        .cp0_entrylo1_wen_i(cp0_entrylo1_wen_i),
        .intr_o(intr_o), .exc_flush_o(exc_flush_o), .exc_target_o(exc_target_o),
        .status_o(status_o), .epc_o(epc_o), .entryhi_o(entryhi_o),
        .entrylo0_o(entrylo0_o), .entrylo1_o(entrylo1_o)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    logic [31:0] m_index, m_elo0, m_elo1, m_ehi, m_status, m_epc, m_count, m_compare;
    logic        m_bd, m_ip7, m_armed, m_phase;
    logic [4:0]  m_code;
    logic [1:0]  m_sw;

    task automatic m_reset();
        m_index = 0; m_elo0 = 0; m_elo1 = 0; m_ehi = 0; m_status = 32'h0040_0000;
        m_epc = 0; m_count = 0; m_compare = 0; m_bd = 0; m_ip7 = 0; m_armed = 0;
        m_phase = 0; m_code = 0; m_sw = 0;
    endtask

    function automatic logic [7:0] m_ip();
        return {m_ip7 | hw_int_i[5], hw_int_i[4:0], m_sw};
    endfunction

    function automatic logic m_intr();
        return ((m_ip() & m_status[15:8]) != 8'h00) && m_status[0] && !m_status[1];
    endfunction

    function automatic logic m_exc();
        return m_intr() || (instr_SYSCALL_i && !m_status[1]);
    endfunction

    function automatic logic m_flush();
        return m_exc() || instr_ERET_i;
    endfunction

    function automatic logic [31:0] m_target();
        if (m_exc()) return m_status[22] ? 32'hBFC0_0380 : 32'h8000_0180;
        if (instr_ERET_i) return m_epc;
        return 32'h0;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        logic [7:0] ip;
        ip = m_ip();
        case (a)
            5'd0:  return m_index;
            5'd2:  return m_elo0;
            5'd3:  return m_elo1;
            5'd9:  return m_count;
            5'd10: return m_ehi;
            5'd11: return m_compare;
            5'd12: return m_status;
            5'd13: return (32'(m_bd) << 31) | (32'(ip[7:2]) << 10) | (32'(m_code) << 2) | 32'(ip[1:0]);
            5'd14: return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_step();
        logic exc, intr, er, wr;
        logic [31:0] cnt_pre, cmp_pre;
        intr = m_intr();
        exc = m_exc();
        er = instr_ERET_i && !exc;
        wr = !exc && !er;
        cnt_pre = m_count;
        cmp_pre = m_compare;
        if (exc) begin
            m_epc = exc_bd_i ? exc_pc_i - 32'd4 : exc_pc_i;
            m_bd = exc_bd_i;
            m_code = intr ? 5'd0 : 5'd8;
            m_status[1] = 1'b1;
        end else if (er) begin
            m_status[1] = 1'b0;
        end else begin
            if (cp0_wen_i) begin
                case (cp0_addr_i)
                    5'd0:  m_index = cp0_data_i & 32'hF;
                    5'd2:  m_elo0 = cp0_data_i & 32'h3FFF_FFFF;
                    5'd3:  m_elo1 = cp0_data_i & 32'h3FFF_FFFF;
                    5'd10: m_ehi = cp0_data_i & 32'hFFFF_E0FF;
                    5'd12: m_status = cp0_data_i & 32'h0040_FF03;
                    5'd13: m_sw = cp0_data_i[1:0];
                    5'd14: m_epc = cp0_data_i;
                    default: ;
                endcase
            end
            if (cp0_entryhi_wen_i) m_ehi = cp0_data_i & 32'hFFFF_E0FF;
            if (cp0_entrylo0_wen_i) m_elo0 = cp0_data_i & 32'h3FFF_FFFF;
            if (cp0_entrylo1_wen_i) m_elo1 = cp0_data_i & 32'h3FFF_FFFF;
        end
        if (wr && cp0_wen_i && cp0_addr_i == 5'd9) m_count = cp0_data_i;
        else if (m_phase) m_count = cnt_pre + 32'd1;
        m_phase = !m_phase;
        if (wr && cp0_wen_i && cp0_addr_i == 5'd11) begin
            m_compare = cp0_data_i; m_ip7 = 1'b0; m_armed = 1'b1;
        end else if (m_armed && cnt_pre == cmp_pre) begin
            m_ip7 = 1'b1; m_armed = 1'b0;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        m_step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        cp0_wen_i = 0; cp0_addr_i = 0; cp0_data_i = 0; instr_ERET_i = 0;
        instr_SYSCALL_i = 0; exc_pc_i = 0; exc_bd_i = 0; hw_int_i = 0;
        cp0_entryhi_wen_i = 0; cp0_entrylo0_wen_i = 0; cp0_entrylo1_wen_i = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        m_reset();
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        cp0_wen_i = 1; cp0_addr_i = a; cp0_data_i = d;
        tick();
        cp0_wen_i = 0; cp0_data_i = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 0;
        m_reset();
        clear_inputs();
        instr_SYSCALL_i = 1;
        cp0_addr_i = 5'd9;
        @(negedge clk);
        #1;
        total_cnt++; if (status_o !== 32'h0040_0000) $display("FAIL reset_status got %h exp %h", status_o, 32'h0040_0000); else pass_cnt++;
        total_cnt++; if (cp0_data_o !== 32'h0) $display("FAIL reset_count got %h exp 0", cp0_data_o); else pass_cnt++;
        total_cnt++; if (intr_o !== 1'b0) $display("FAIL reset_intr got %b exp 0", intr_o); else pass_cnt++;
        total_cnt++; if (exc_flush_o !== 1'b0 || exc_target_o !== 32'h0) $display("FAIL reset_flush got %b/%h exp 0/0", exc_flush_o, exc_target_o); else pass_cnt++;
        total_cnt++; if (epc_o !== 32'h0 || entryhi_o !== 32'h0) $display("FAIL reset_regs got %h/%h exp 0/0", epc_o, entryhi_o); else pass_cnt++;
        @(negedge clk);
        instr_SYSCALL_i = 0;
        rst_n = 1;
        for (int i = 0; i < 10; i++) tick();
        #1;
        total_cnt++; if (cp0_data_o !== 32'd5) $display("FAIL count_after_10 got %0d exp 5", cp0_data_o); else pass_cnt++;
    endtask

    task automatic test_masks();
        do_reset();
        cp0_wen_i = 1; cp0_addr_i = 5'd12; cp0_data_i = 32'hFFFF_FFFF;
        #1;
        total_cnt++; if (cp0_data_o !== 32'h0040_0000) $display("FAIL no_bypass got %h exp %h", cp0_data_o, 32'h0040_0000); else pass_cnt++;
        tick();
        cp0_wen_i = 0;
        #1;
        total_cnt++; if (cp0_data_o !== 32'h0040_FF03) $display("FAIL status_mask got %h exp %h", cp0_data_o, 32'h0040_FF03); else pass_cnt++;
        mtc0(5'd13, 32'hFFFF_FFFF);
        cp0_addr_i = 5'd13;
        #1;
        total_cnt++; if (cp0_data_o !== 32'h0000_0003) $display("FAIL cause_mask got %h exp %h", cp0_data_o, 32'h0000_0003); else pass_cnt++;
        mtc0(5'd0, 32'hFFFF_FFFF);
        cp0_addr_i = 5'd0;
        #1;
        total_cnt++; if (cp0_data_o !== 32'h0000_000F) $display("FAIL index_mask got %h exp %h", cp0_data_o, 32'hF); else pass_cnt++;
        mtc0(5'd8, 32'h1234_5678);
        cp0_addr_i = 5'd8;
        #1;
        total_cnt++; if (cp0_data_o !== 32'h0) $display("FAIL badvaddr_ro got %h exp 0", cp0_data_o); else pass_cnt++;
    endtask

    task automatic test_timer_intr();
        bit seen;
        do_reset();
        mtc0(5'd12, 32'h0000_8001);
        mtc0(5'd11, 32'd20);
        exc_pc_i = 32'h8000_1000; exc_bd_i = 0; cp0_addr_i = 5'd9;
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (intr_o === 1'b1) begin seen = 1; break; end
            tick();
        end
        total_cnt++; if (!seen) $display("FAIL timer_intr_timeout got intr=%b exp 1", intr_o); else pass_cnt++;
        total_cnt++; if (cp0_data_o !== 32'd20) $display("FAIL timer_count_at_intr got %0d exp 20", cp0_data_o); else pass_cnt++;
        total_cnt++; if (exc_flush_o !== 1'b1 || exc_target_o !== 32'h8000_0180) $display("FAIL timer_vector got %b/%h exp 1/%h", exc_flush_o, exc_target_o, 32'h8000_0180); else pass_cnt++;
        tick();
        #1;
        total_cnt++; if (epc_o !== 32'h8000_1000) $display("FAIL timer_epc got %h exp %h", epc_o, 32'h8000_1000); else pass_cnt++;
        total_cnt++; if (status_o[1] !== 1'b1 || intr_o !== 1'b0) $display("FAIL timer_exl got exl=%b intr=%b exp 1/0", status_o[1], intr_o); else pass_cnt++;
    endtask

    task automatic test_syscall_eret();
        do_reset();
        mtc0(5'd12, 32'h0);
        instr_SYSCALL_i = 1; exc_bd_i = 1; exc_pc_i = 32'h8000_2004; cp0_addr_i = 5'd13;
        #1;
        total_cnt++; if (exc_flush_o !== 1'b1 || exc_target_o !== 32'h8000_0180) $display("FAIL sys_vector got %b/%h exp 1/%h", exc_flush_o, exc_target_o, 32'h8000_0180); else pass_cnt++;
        tick();
        #1;
        total_cnt++; if (epc_o !== 32'h8000_2000) $display("FAIL sys_epc got %h exp %h", epc_o, 32'h8000_2000); else pass_cnt++;
        total_cnt++; if (cp0_data_o !== 32'h8000_0020) $display("FAIL sys_cause got %h exp %h", cp0_data_o, 32'h8000_0020); else pass_cnt++;
        total_cnt++; if (status_o !== 32'h0000_0002) $display("FAIL sys_status got %h exp %h", status_o, 32'h2); else pass_cnt++;
        exc_pc_i = 32'h8000_5000; exc_bd_i = 0;
        #1;
        total_cnt++; if (exc_flush_o !== 1'b0) $display("FAIL nested_sys_flush got %b exp 0", exc_flush_o); else pass_cnt++;
        tick();
        instr_SYSCALL_i = 0;
        #1;
        total_cnt++; if (epc_o !== 32'h8000_2000 || cp0_data_o !== 32'h8000_0020) $display("FAIL nested_sys_state got %h/%h exp %h/%h", epc_o, cp0_data_o, 32'h8000_2000, 32'h8000_0020); else pass_cnt++;
        instr_ERET_i = 1;
        #1;
        total_cnt++; if (exc_flush_o !== 1'b1 || exc_target_o !== 32'h8000_2000) $display("FAIL eret_target got %b/%h exp 1/%h", exc_flush_o, exc_target_o, 32'h8000_2000); else pass_cnt++;
        tick();
        instr_ERET_i = 0;
        #1;
        total_cnt++; if (status_o !== 32'h0) $display("FAIL eret_exl got %h exp 0", status_o); else pass_cnt++;
        mtc0(5'd13, 32'h1);
        mtc0(5'd12, 32'h0000_0101);
        instr_ERET_i = 1; exc_pc_i = 32'h8000_3000; exc_bd_i = 0;
        #1;
        total_cnt++; if (intr_o !== 1'b1 || exc_target_o !== 32'h8000_0180) $display("FAIL eret_vs_intr got %b/%h exp 1/%h", intr_o, exc_target_o, 32'h8000_0180); else pass_cnt++;
        tick();
        instr_ERET_i = 0;
        #1;
        total_cnt++; if (status_o !== 32'h0000_0103 || epc_o !== 32'h8000_3000) $display("FAIL eret_vs_intr_state got %h/%h exp %h/%h", status_o, epc_o, 32'h103, 32'h8000_3000); else pass_cnt++;
    endtask

    task automatic test_drop_and_midreset();
        do_reset();
        mtc0(5'd12, 32'h0);
        instr_SYSCALL_i = 1; exc_pc_i = 32'h8000_4000;
        cp0_wen_i = 1; cp0_addr_i = 5'd10; cp0_data_i = 32'hFFFF_FFFF; cp0_entryhi_wen_i = 1;
        tick();
        clear_inputs();
        #1;
        total_cnt++; if (entryhi_o !== 32'h0) $display("FAIL drop_entryhi got %h exp 0", entryhi_o); else pass_cnt++;
        cp0_entryhi_wen_i = 1; cp0_entrylo1_wen_i = 1; cp0_data_i = 32'hFFFF_FFFF;
        tick();
        clear_inputs();
        #1;
        total_cnt++; if (entryhi_o !== 32'hFFFF_E0FF || entrylo1_o !== 32'h3FFF_FFFF) $display("FAIL tlb_strobe got %h/%h exp %h/%h", entryhi_o, entrylo1_o, 32'hFFFF_E0FF, 32'h3FFF_FFFF); else pass_cnt++;
        instr_SYSCALL_i = 1; cp0_addr_i = 5'd10;
        #2;
        rst_n = 0;
        m_reset();
        #1;
        total_cnt++; if (status_o !== 32'h0040_0000 || epc_o !== 32'h0 || entryhi_o !== 32'h0 || entrylo1_o !== 32'h0) $display("FAIL midreset_regs got %h/%h/%h/%h exp reset values", status_o, epc_o, entryhi_o, entrylo1_o); else pass_cnt++;
        total_cnt++; if (exc_flush_o !== 1'b0 || cp0_data_o !== 32'h0) $display("FAIL midreset_outputs got %b/%h exp 0/0", exc_flush_o, cp0_data_o); else pass_cnt++;
        @(negedge clk);
        clear_inputs();
        rst_n = 1;
    endtask

    task automatic test_count_wrap();
        do_reset();
        mtc0(5'd9, 32'hFFFF_FFFF);
        cp0_addr_i = 5'd9;
        #1;
        total_cnt++; if (cp0_data_o !== 32'hFFFF_FFFF) $display("FAIL count_write got %h exp %h", cp0_data_o, 32'hFFFF_FFFF); else pass_cnt++;
        tick();
        tick();
        #1;
        total_cnt++; if (cp0_data_o !== 32'h0) $display("FAIL count_wrap got %h exp 0", cp0_data_o); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [4:0] addr_tab [12];
        addr_tab = '{5'd0, 5'd2, 5'd3, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd5, 5'd20};
        do_reset();
        for (int n = 0; n < 600; n++) begin
            cp0_wen_i = ($urandom_range(0, 2) == 0);
            cp0_addr_i = addr_tab[$urandom_range(0, 11)];
            cp0_data_i = $urandom;
            if (cp0_addr_i == 5'd11 && $urandom_range(0, 1) == 1) cp0_data_i = m_count + 32'($urandom_range(0, 4));
            cp0_entryhi_wen_i = ($urandom_range(0, 7) == 0);
            cp0_entrylo0_wen_i = ($urandom_range(0, 7) == 0);
            cp0_entrylo1_wen_i = ($urandom_range(0, 7) == 0);
            instr_SYSCALL_i = ($urandom_range(0, 9) == 0);
            instr_ERET_i = ($urandom_range(0, 9) == 0);
            hw_int_i = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h0;
            exc_pc_i = $urandom & 32'hFFFF_FFFC;
            exc_bd_i = 1'($urandom);
            #1;
            total_cnt++; if (cp0_data_o !== m_read(cp0_addr_i)) $display("FAIL rnd_read[%0d] addr %0d got %h exp %h", n, cp0_addr_i, cp0_data_o, m_read(cp0_addr_i)); else pass_cnt++;
            total_cnt++; if (intr_o !== m_intr()) $display("FAIL rnd_intr[%0d] got %b exp %b", n, intr_o, m_intr()); else pass_cnt++;
            total_cnt++; if (exc_flush_o !== m_flush() || exc_target_o !== m_target()) $display("FAIL rnd_redirect[%0d] got %b/%h exp %b/%h", n, exc_flush_o, exc_target_o, m_flush(), m_target()); else pass_cnt++;
            total_cnt++; if (status_o !== m_status || epc_o !== m_epc) $display("FAIL rnd_status_epc[%0d] got %h/%h exp %h/%h", n, status_o, epc_o, m_status, m_epc); else pass_cnt++;
            total_cnt++; if (entryhi_o !== m_ehi || entrylo0_o !== m_elo0 || entrylo1_o !== m_elo1) $display("FAIL rnd_tlb[%0d] got %h/%h/%h exp %h/%h/%h", n, entryhi_o, entrylo0_o, entrylo1_o, m_ehi, m_elo0, m_elo1); else pass_cnt++;
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_masks();
        test_timer_intr();
        test_syscall_eret();
        test_drop_and_midreset();
        test_count_wrap();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
